// File: rtl/tcn_fifo_scheduler_pkg.sv
// Shared definitions for the TCN FIFO scheduler and encoder_FIFO:
// FSM states, default widths and the packed block-size layout.
package tcn_fifo_scheduler_pkg;

   localparam int TCN_ADDR_W = 14;
   localparam int TCN_TAPS_W = 4;
   localparam int TCN_SETTLE = 2;
   localparam int BSIZE_W    = 16;
   localparam int BS_WR_LSB  = 16;
   localparam int BS_RD_LSB  = 0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WRITE  = 3'd1,
      ST_READ   = 3'd2,
      ST_UPDATE = 3'd3,
      ST_SETTLE = 3'd4
   } state_e;

   function automatic logic [31:0] pack_bsize(input logic [BSIZE_W-1:0] wr_bsize,
                                              input logic [BSIZE_W-1:0] rd_bsize);
      logic [31:0] packed_v;
      packed_v = 32'd0;
      packed_v[BS_WR_LSB +: BSIZE_W] = wr_bsize;
      packed_v[BS_RD_LSB +: BSIZE_W] = rd_bsize;
      return packed_v;
   endfunction

endpackage

// File: rtl/tcn_addr_gen.sv
// Word/tap counters and tap_base accumulator for one TCN step.
// Provides next-cycle logical address so the top can register it.
module tcn_addr_gen
   import tcn_fifo_scheduler_pkg::*;
#(
   parameter int ADDR_W = TCN_ADDR_W,
   parameter int TAPS_W = TCN_TAPS_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               advance,
   input  logic [BSIZE_W-1:0] bsize,
   input  logic [TAPS_W-1:0]  num_taps,
   input  logic [ADDR_W-1:0]  step,
   output logic               word_last,
   output logic               tap_last,
   output logic [ADDR_W-1:0]  addr_nxt
);

   logic [BSIZE_W-1:0] word_r, word_nxt_s;
   logic [TAPS_W-1:0]  tap_r, tap_nxt_s;
   logic [ADDR_W-1:0]  base_r, base_nxt_s;

   assign word_last = (word_r == (bsize - BSIZE_W'(1)));
   assign tap_last  = (tap_r == (num_taps - TAPS_W'(1)));
   assign addr_nxt  = base_nxt_s + ADDR_W'(word_nxt_s);

   // Next counter values; a finished block jumps tap_base by one dilation stride
   always_comb begin
      word_nxt_s = word_r;
      tap_nxt_s  = tap_r;
      base_nxt_s = base_r;
      if (clear) begin
         word_nxt_s = {BSIZE_W{1'b0}};
         tap_nxt_s  = {TAPS_W{1'b0}};
         base_nxt_s = {ADDR_W{1'b0}};
      end else if (advance) begin
         if (word_last) begin
            word_nxt_s = {BSIZE_W{1'b0}};
            tap_nxt_s  = tap_r + TAPS_W'(1);
            base_nxt_s = base_r + step;
         end else begin
            word_nxt_s = word_r + BSIZE_W'(1);
         end
      end else begin
         word_nxt_s = word_r;
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_r <= {BSIZE_W{1'b0}};
         tap_r  <= {TAPS_W{1'b0}};
         base_r <= {ADDR_W{1'b0}};
      end else begin
         word_r <= word_nxt_s;
         tap_r  <= tap_nxt_s;
         base_r <= base_nxt_s;
      end
   end

endmodule

// File: rtl/tcn_fifo_scheduler.sv
// Sequences one TCN time step (write new block, read dilated taps, advance
// the encoder_FIFO pointer) and emits logical addresses only.
module tcn_fifo_scheduler
   import tcn_fifo_scheduler_pkg::*;
#(
   parameter int ADDR_W = TCN_ADDR_W,
   parameter int TAPS_W = TCN_TAPS_W,
   parameter int SETTLE = TCN_SETTLE
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [ADDR_W-1:0]  cfg_total_blocks,
   input  logic [BSIZE_W-1:0] cfg_rd_bsize,
   input  logic [BSIZE_W-1:0] cfg_wr_bsize,
   input  logic [TAPS_W-1:0]  cfg_num_taps,
   input  logic [ADDR_W-1:0]  cfg_dilation,
   input  logic               mem_ready,
   output logic               rd_enable,
   output logic [ADDR_W-1:0]  rd_address,
   output logic               wr_enable,
   output logic [ADDR_W-1:0]  wr_address,
   output logic               fifo_active,
   output logic               fifo_update,
   output logic [31:0]        fifo_block_size,
   output logic               busy,
   output logic               done,
   output logic               cfg_err
);

   localparam int SPAN_W = TAPS_W + ADDR_W;
   localparam int FOOT_W = ADDR_W + BSIZE_W + 1;
   localparam int STEP_W = ADDR_W + BSIZE_W;
   localparam int SC_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SC_W-1:0]   SETTLE_LAST = SC_W'(SETTLE - 1);
   localparam logic [FOOT_W-1:0] MEM_WORDS   = FOOT_W'(1) << ADDR_W;

   state_e              state_r, state_nxt_s;
   logic [SC_W-1:0]     settle_r, settle_nxt_s;
   logic                accept_s, err_start_s, clear_s, advance_s;
   logic [31:0]         block_size_r;
   logic [TAPS_W-1:0]   num_taps_r;
   logic [ADDR_W-1:0]   step_r;
   logic [BSIZE_W-1:0]  gen_bsize_s, max_bsize_s;
   logic                word_last_s, tap_last_s;
   logic [ADDR_W-1:0]   addr_nxt_s;
   logic [SPAN_W-1:0]   span_s;
   logic [FOOT_W-1:0]   footprint_s;
   logic                cfg_bad_s;
   logic                rd_enable_r, wr_enable_r, active_r, update_r, done_r, cfg_err_r;
   logic [ADDR_W-1:0]   rd_address_r, wr_address_r;

   // Furthest tap must stay inside the FIFO and the whole FIFO inside memory
   assign max_bsize_s = (cfg_wr_bsize > cfg_rd_bsize) ? cfg_wr_bsize : cfg_rd_bsize;
   assign span_s      = SPAN_W'(cfg_num_taps - TAPS_W'(1)) * SPAN_W'(cfg_dilation);
   assign footprint_s = FOOT_W'(cfg_total_blocks) * FOOT_W'(max_bsize_s);
   assign cfg_bad_s   = (cfg_total_blocks == {ADDR_W{1'b0}}) || (cfg_num_taps == {TAPS_W{1'b0}})
                     || (cfg_dilation == {ADDR_W{1'b0}}) || (cfg_wr_bsize == {BSIZE_W{1'b0}})
                     || (cfg_rd_bsize == {BSIZE_W{1'b0}})
                     || (span_s >= SPAN_W'(cfg_total_blocks)) || (footprint_s > MEM_WORDS);

   assign gen_bsize_s = (state_r == ST_READ) ? block_size_r[BS_RD_LSB +: BSIZE_W]
                                             : block_size_r[BS_WR_LSB +: BSIZE_W];

   tcn_addr_gen #(
      .ADDR_W (ADDR_W),
      .TAPS_W (TAPS_W)
   ) u_addr_gen (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear_s),
      .advance   (advance_s),
      .bsize     (gen_bsize_s),
      .num_taps  (num_taps_r),
      .step      (step_r),
      .word_last (word_last_s),
      .tap_last  (tap_last_s),
      .addr_nxt  (addr_nxt_s)
   );

   // Next-state logic; abort has priority in every state
   always_comb begin
      state_nxt_s  = state_r;
      settle_nxt_s = settle_r;
      accept_s     = 1'b0;
      err_start_s  = 1'b0;
      clear_s      = 1'b0;
      advance_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (start && cfg_bad_s) begin
               err_start_s = 1'b1;
            end else if (start) begin
               accept_s    = 1'b1;
               clear_s     = 1'b1;
               state_nxt_s = ST_WRITE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (mem_ready) begin
               advance_s = 1'b1;
               if (word_last_s) begin
                  clear_s     = 1'b1;
                  state_nxt_s = ST_READ;
               end else begin
                  state_nxt_s = ST_WRITE;
               end
            end else begin
               state_nxt_s = ST_WRITE;
            end
         end
         ST_READ: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (mem_ready) begin
               advance_s = 1'b1;
               if (word_last_s && tap_last_s) begin
                  state_nxt_s = ST_UPDATE;
               end else begin
                  state_nxt_s = ST_READ;
               end
            end else begin
               state_nxt_s = ST_READ;
            end
         end
         ST_UPDATE: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s  = ST_SETTLE;
               settle_nxt_s = {SC_W{1'b0}};
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (settle_r == SETTLE_LAST) begin
               state_nxt_s = ST_IDLE;
            end else begin
               settle_nxt_s = settle_r + SC_W'(1);
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State and settle counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= ST_IDLE;
         settle_r <= {SC_W{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         settle_r <= settle_nxt_s;
      end
   end

   // Config shadow, loaded only when a legal step is accepted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         block_size_r <= 32'd0;
         num_taps_r   <= {TAPS_W{1'b0}};
         step_r       <= {ADDR_W{1'b0}};
      end else if (accept_s) begin
         block_size_r <= pack_bsize(cfg_wr_bsize, cfg_rd_bsize);
         num_taps_r   <= cfg_num_taps;
         step_r       <= ADDR_W'(STEP_W'(cfg_dilation) * STEP_W'(cfg_rd_bsize));
      end else begin
         block_size_r <= block_size_r;
         num_taps_r   <= num_taps_r;
         step_r       <= step_r;
      end
   end

   // Output registers, decoded from the next state so they align with it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_enable_r  <= 1'b0;
         rd_enable_r  <= 1'b0;
         wr_address_r <= {ADDR_W{1'b0}};
         rd_address_r <= {ADDR_W{1'b0}};
         active_r     <= 1'b0;
         update_r     <= 1'b0;
         done_r       <= 1'b0;
         cfg_err_r    <= 1'b0;
      end else begin
         wr_enable_r  <= (state_nxt_s == ST_WRITE);
         rd_enable_r  <= (state_nxt_s == ST_READ);
         wr_address_r <= (state_nxt_s == ST_WRITE) ? addr_nxt_s : {ADDR_W{1'b0}};
         rd_address_r <= (state_nxt_s == ST_READ) ? addr_nxt_s : {ADDR_W{1'b0}};
         active_r     <= (state_nxt_s != ST_IDLE);
         update_r     <= (state_nxt_s == ST_UPDATE);
         done_r       <= err_start_s || ((state_nxt_s == ST_SETTLE) && (settle_nxt_s == SETTLE_LAST));
         if (err_start_s) begin
            cfg_err_r <= 1'b1;
         end else if (accept_s) begin
            cfg_err_r <= 1'b0;
         end else begin
            cfg_err_r <= cfg_err_r;
         end
      end
   end

   assign rd_enable       = rd_enable_r;
   assign rd_address      = rd_address_r;
   assign wr_enable       = wr_enable_r;
   assign wr_address      = wr_address_r;
   assign fifo_active     = active_r;
   assign busy            = active_r;
   assign fifo_update     = update_r;
   assign done            = done_r;
   assign cfg_err         = cfg_err_r;
   assign fifo_block_size = block_size_r;

endmodule

// File: tb/tb_tcn_fifo_scheduler.sv
// Directed bench for tcn_fifo_scheduler with hand-derived address sequences
// and a small encoder_FIFO pointer model for the wrap test.
module tb_tcn_fifo_scheduler;

   logic        clk;
   logic        reset;
   logic        start;
   logic        abort;
   logic [13:0] cfg_total_blocks;
   logic [15:0] cfg_rd_bsize;
   logic [15:0] cfg_wr_bsize;
   logic [3:0]  cfg_num_taps;
   logic [13:0] cfg_dilation;
   logic        mem_ready;
   logic        rd_enable;
   logic [13:0] rd_address;
   logic        wr_enable;
   logic [13:0] wr_address;
   logic        fifo_active;
   logic        fifo_update;
   logic [31:0] fifo_block_size;
   logic        busy;
   logic        done;
   logic        cfg_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [13:0] wr_q[$];
   logic [13:0] rd_q[$];
   int n_upd, upd_cyc, done_cyc, both_hi, hold_err;
   logic busy_first, cfg_err_first;
   int ptr;

   tcn_fifo_scheduler dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .abort            (abort),
      .cfg_total_blocks (cfg_total_blocks),
      .cfg_rd_bsize     (cfg_rd_bsize),
      .cfg_wr_bsize     (cfg_wr_bsize),
      .cfg_num_taps     (cfg_num_taps),
      .cfg_dilation     (cfg_dilation),
      .mem_ready        (mem_ready),
      .rd_enable        (rd_enable),
      .rd_address       (rd_address),
      .wr_enable        (wr_enable),
      .wr_address       (wr_address),
      .fifo_active      (fifo_active),
      .fifo_update      (fifo_update),
      .fifo_block_size  (fifo_block_size),
      .busy             (busy),
      .done             (done),
      .cfg_err          (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
      end
   endtask

   task automatic set_cfg(input int tot, input int wrb, input int rdb, input int taps, input int dil);
      cfg_total_blocks = 14'(tot);
      cfg_wr_bsize     = 16'(wrb);
      cfg_rd_bsize     = 16'(rdb);
      cfg_num_taps     = 4'(taps);
      cfg_dilation     = 14'(dil);
   endtask

   function automatic int out_bits();
      return int'({rd_enable, wr_enable, fifo_active, fifo_update, busy, done});
   endfunction

   // Pulse start, then record transfers, pulses and hold behaviour until done
   task automatic run_step(input bit toggle, input int restart_c, input int max_cyc);
      logic        prev_en, prev_rdy, prev_rd;
      logic [13:0] prev_addr;
      wr_q.delete();
      rd_q.delete();
      n_upd = 0; upd_cyc = -1; done_cyc = -1; both_hi = 0; hold_err = 0;
      prev_en = 1'b0; prev_rdy = 1'b1; prev_rd = 1'b0; prev_addr = 14'd0;
      @(negedge clk);
      start     = 1'b1;
      mem_ready = 1'b1;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         start     = (c == restart_c);
         mem_ready = toggle ? ((c % 2) == 0) : 1'b1;
         if (c == 0) begin
            busy_first    = busy;
            cfg_err_first = cfg_err;
         end
         if (wr_enable && rd_enable) both_hi++;
         if (prev_en && !prev_rdy && (!(wr_enable || rd_enable) || (rd_enable != prev_rd) ||
             ((rd_enable ? rd_address : wr_address) != prev_addr))) hold_err++;
         if (wr_enable && mem_ready) wr_q.push_back(wr_address);
         if (rd_enable && mem_ready) rd_q.push_back(rd_address);
         if (fifo_update) begin
            n_upd++;
            upd_cyc = c;
         end
         prev_en   = wr_enable | rd_enable;
         prev_rdy  = mem_ready;
         prev_rd   = rd_enable;
         prev_addr = rd_enable ? rd_address : wr_address;
         if (done) begin
            done_cyc = c;
            break;
         end
      end
      start     = 1'b0;
      mem_ready = 1'b1;
   endtask

   // Compare the recorded step against block 0 writes and taps at t*dil*rd_bs
   task automatic check_seq(input string tag, input int taps, input int dil, input int wr_bs, input int rd_bs);
      int idx;
      check_eq({tag, "_wr_len"}, wr_q.size(), wr_bs);
      for (int i = 0; i < wr_q.size() && i < wr_bs; i++)
         check_eq({tag, "_wr_addr"}, int'(wr_q[i]), i);
      check_eq({tag, "_rd_len"}, rd_q.size(), taps * rd_bs);
      idx = 0;
      for (int t = 0; t < taps; t++) begin
         for (int w = 0; w < rd_bs; w++) begin
            if (idx < rd_q.size()) check_eq({tag, "_rd_addr"}, int'(rd_q[idx]), t * dil * rd_bs + w);
            idx++;
         end
      end
      check_eq({tag, "_both_en"}, both_hi, 0);
      check_eq({tag, "_upd_cnt"}, n_upd, 1);
      check_eq({tag, "_done_gap"}, done_cyc - upd_cyc, 2);
      check_eq({tag, "_busy"}, int'(busy_first), 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0; mem_ready = 1'b1;
      set_cfg(8, 4, 4, 3, 2);
      repeat (3) @(negedge clk);
      check_eq("reset_flags", out_bits(), 0);
      check_eq("reset_addr", int'({rd_address, wr_address}), 0);
      check_eq("reset_bsize", int'(fifo_block_size), 0);
      check_eq("reset_cfg_err", int'(cfg_err), 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // 1: basic step with always-ready memory
      run_step(1'b0, -1, 40);
      check_seq("t1", 3, 2, 4, 4);
      check_eq("t1_upd_cyc", upd_cyc, 16);
      check_eq("t1_done_cyc", done_cyc, 18);
      check_eq("t1_bsize", int'(fifo_block_size), 32'h0004_0004);
      @(negedge clk);
      check_eq("t1_idle_after", int'({busy, fifo_active, done}), 0);

      // 2: mem_ready toggling
      run_step(1'b1, -1, 80);
      check_seq("t2", 3, 2, 4, 4);
      check_eq("t2_hold", hold_err, 0);

      // 3: illegal config, furthest tap reaches total_blocks
      set_cfg(4, 4, 4, 3, 2);
      run_step(1'b0, -1, 5);
      check_eq("t3_done_cyc", done_cyc, 0);
      check_eq("t3_cfg_err", int'(cfg_err_first), 1);
      check_eq("t3_no_busy", int'(busy_first), 0);
      check_eq("t3_no_access", wr_q.size() + rd_q.size(), 0);
      check_eq("t3_no_update", n_upd, 0);
      repeat (3) @(negedge clk);
      check_eq("t3_err_sticky", int'({cfg_err, busy, done}), 3'b100);

      // 4: eight steps through an encoder_FIFO pointer model, furthest tap at total-1
      set_cfg(4, 2, 2, 2, 3);
      ptr = 0;
      for (int k = 0; k < 8; k++) begin
         run_step(1'b0, -1, 30);
         if (k == 0) check_eq("t4_err_cleared", int'(cfg_err_first), 0);
         check_eq("t4_rd_len", rd_q.size(), 4);
         for (int i = 0; i < wr_q.size(); i++)
            check_eq("t4_wr_phys", (int'(wr_q[i]) + ptr * 2) % 8, ptr * 2 + i);
         for (int t = 0; t < 2; t++)
            for (int w = 0; w < 2; w++)
               if (t * 2 + w < rd_q.size())
                  check_eq("t4_rd_phys", (int'(rd_q[t * 2 + w]) + ptr * 2) % 8, ((t * 3 + ptr) % 4) * 2 + w);
         check_eq("t4_upd", n_upd, 1);
         ptr = (ptr + n_upd) % 4;
         if (k == 3) check_eq("t4_wrap_ptr", ptr, 0);
      end
      check_eq("t4_final_ptr", ptr, 0);

      // 5: abort during READ tap 1
      set_cfg(8, 4, 4, 3, 2);
      begin
         int hit, seen;
         hit = 0;
         @(negedge clk);
         start = 1'b1;
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (rd_enable && rd_address == 14'd9) begin
               abort = 1'b1;
               hit = 1;
               break;
            end
         end
         check_eq("t5_abort_reached", hit, 1);
         @(negedge clk);
         abort = 1'b0;
         check_eq("t5_idle_now", out_bits(), 0);
         seen = 0;
         repeat (6) begin
            @(negedge clk);
            if (fifo_update || done) seen++;
         end
         check_eq("t5_no_upd_done", seen, 0);
         @(negedge clk);
         start = 1'b1;
         abort = 1'b1;
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         check_eq("t5_abort_wins", int'({busy, done}), 0);
      end
      run_step(1'b0, -1, 40);
      check_seq("t5_clean", 3, 2, 4, 4);

      // 6: start while busy is ignored, then async reset mid-WRITE
      run_step(1'b0, 2, 40);
      check_seq("t6_restart", 3, 2, 4, 4);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_eq("t6_async_flags", out_bits(), 0);
      check_eq("t6_async_addr", int'({rd_address, wr_address}), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("t6_post_reset", int'({busy, cfg_err}), 0);
      check_eq("t6_post_bsize", int'(fifo_block_size), 0);
      run_step(1'b0, -1, 40);
      check_seq("t6_clean", 3, 2, 4, 4);

      // Memory-size boundary: total*bsize equal to 2^14 is legal, one block more is not
      set_cfg(4096, 4, 4, 1, 1);
      run_step(1'b0, -1, 20);
      check_eq("bnd_ok_err", int'(cfg_err_first), 0);
      check_eq("bnd_ok_rd_len", rd_q.size(), 4);
      set_cfg(4097, 4, 4, 1, 1);
      run_step(1'b0, -1, 5);
      check_eq("bnd_bad_err", int'(cfg_err_first), 1);
      check_eq("bnd_bad_done", done_cyc, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
